pe_result_fifo: RTL
===================

Name: pe_result_fifo

Overview:
- Downstream stage of the priority-encoder/parity-checker.
- Captures each strobed result (encoded index, any-bit flag, parity-error flag) into a small FIFO and drains it through a valid/ready port to the output mux / uio logic.
- Keeps a saturating parity-error counter and a sticky drop flag, so bursts are not lost silently when the consumer stalls.

Parameters:
- IDX_W, 3, width of the encoded priority index.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the parity-error counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  result strobe from the encoder stage.
- in_idx  input  IDX_W  encoded index of the highest set input bit.
- in_any  input  1  at least one input bit set.
- in_perr  input  1  parity mismatch flagged by the checker.
- in_ready  output  1  FIFO not full.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts the head.
- out_data  output  IDX_W+2  head entry {perr, any, idx}; perr is the MSB.
- level  output  $clog2(DEPTH)+1  current occupancy.
- err_cnt  output  CNT_W  saturating count of accepted entries with perr=1.
- drop  output  1  sticky: a strobe was lost because the FIFO was full.
- clr  input  1  synchronous clear of err_cnt and drop; FIFO contents untouched.

Behaviour:
- Single clock domain. Reset is synchronous, active-high.
- Reset values: level=0, out_valid=0, out_data=0, in_ready=1, err_cnt=0, drop=0, read/write pointers=0.
- Push: in_valid && in_ready. Entry written at the write pointer; write pointer increments modulo DEPTH (natural wrap).
- Pop: out_valid && out_ready. Read pointer increments modulo DEPTH.
- out_data is driven combinationally from storage at the read pointer. It is 0 when empty.
- Latency: entry pushed in cycle N appears on out_valid/out_data in cycle N+1. No bypass.
- Full (level==DEPTH):
  - in_ready=0.
  - in_valid in this state is not stored and sets drop=1.
  - A simultaneous pop does NOT admit the push; in_ready is registered-state based only.
- Empty (level==0):
  - out_valid=0.
  - A simultaneous push and out_ready performs no pop.
- Simultaneous push and pop when 0<level<DEPTH: level unchanged, both pointers advance.
- err_cnt:
  - Increments by 1 on each accepted push with in_perr=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - Dropped strobes do not count.
- clr:
  - Zeroes err_cnt and drop next cycle.
  - If clr and an error push coincide, clr wins (err_cnt=0).
  - If clr and a drop coincide, clr wins (drop=0).
- Reset mid-operation: all state returns to reset values next edge; buffered entries are discarded.
- Entries with in_any=0 are stored normally (idx expected 0).

Optional Feature:
- Macro: PE_RESULT_CHANGE_FILTER_EN.
- When defined:
  - A register holds the last accepted entry plus a valid bit, cleared by rst.
  - An in_valid whose {perr,any,idx} equals that register is silently discarded: no push, no drop, no err_cnt change.
  - The first strobe after reset is always accepted.
  - A filtered strobe while full does not set drop.
- When undefined: every strobe is processed as above; no extra state.

Decomposition:
- Package pe_pkg:
  - IDX_W default constant.
  - typedef pe_result_t as a packed struct {perr, any, idx[IDX_W-1:0]}, MSB first.
  - CNT_W default constant.
- One natural sub-module: pe_sync_fifo. It holds generic storage, pointers and level, with push/pop/full/empty.
- The top adds err_cnt, drop, clr and the optional filter.

Test Plan:
- Reset, then push idx=5, any=1, perr=0 with out_ready=0 → next cycle out_valid=1, out_data=0x0D, level=1.
- Push 4 entries (idx 1,2,3,4, perr=1 on idx 2 and 4), out_ready=0 → level=4, in_ready=0, err_cnt=2. A fifth strobe → drop=1, level stays 4. Drain → order 1,2,3,4.
- level=2, push and pop in the same cycle → level stays 2; popped data is the oldest entry.
- Drive 260 accepted perr=1 pushes with out_ready=1 (CNT_W=8) → err_cnt holds 255. Assert clr → err_cnt=0, drop=0 next cycle.
- Push 3 entries, assert rst for 1 cycle → level=0, out_valid=0, err_cnt=0; next push appears normally.
- PE_RESULT_CHANGE_FILTER_EN defined: strobe idx=3 three times, then idx=4 → exactly 2 entries (3, 4) stored. Without the macro → 4 entries.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and default sizing for the priority-encoder result path.
// An entry is {perr, any, idx}; perr is the MSB.
package pe_pkg;

  localparam int PE_IDX_W = 3;
  localparam int PE_DEPTH = 4;
  localparam int PE_CNT_W = 8;

  typedef struct packed {
    logic                perr;
    logic                any;
    logic [PE_IDX_W-1:0] idx;
  } pe_result_t;

  function automatic pe_result_t pe_pack(input logic perr, input logic any,
                                         input logic [PE_IDX_W-1:0] idx);
    pe_result_t r;
    r.perr = perr;
    r.any  = any;
    r.idx  = idx;
    return r;
  endfunction

endpackage

// File: rtl/pe_sync_fifo.sv
// Generic single-clock FIFO: one-cycle write-to-read latency, no bypass.
// Pushes while full and pops while empty are ignored; read data is zero when empty.
module pe_sync_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

  a_level_bound: assert property (@(posedge clk) disable iff (rst)
    level_q <= LW'(DEPTH));
  a_no_wrap: assert property (@(posedge clk) disable iff (rst)
    (level_q != '0) || !do_pop);

endmodule

// File: rtl/pe_result_fifo.sv
// Buffers encoder results behind valid/ready with a saturating parity-error count and sticky drop.
// Optional PE_RESULT_CHANGE_FILTER_EN discards strobes identical to the last accepted entry.
module pe_result_fifo
  import pe_pkg::*;
#(
  parameter int IDX_W = PE_IDX_W,
  parameter int DEPTH = PE_DEPTH,
  parameter int CNT_W = PE_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [IDX_W-1:0]       in_idx,
  input  logic                   in_any,
  input  logic                   in_perr,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W+1:0]       out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       err_cnt,
  output logic                   drop,
  input  logic                   clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [IDX_W+1:0] in_entry;
  logic             filtered;
  logic             strobe;
  logic             push_acc;
  logic             lost;
  logic             pop;
  logic             full, empty;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             drop_q, drop_d;

  assign in_entry = {in_perr, in_any, in_idx};

`ifdef PE_RESULT_CHANGE_FILTER_EN
  logic [IDX_W+1:0] last_q;
  logic             last_vld_q;

  assign filtered = in_valid && last_vld_q && (in_entry == last_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (push_acc) begin
      last_q     <= in_entry;
      last_vld_q <= 1'b1;
    end
  end
`else
  assign filtered = 1'b0;
`endif

  // Readiness comes from registered occupancy only: a same-cycle pop never frees a slot.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign strobe    = in_valid && !filtered;
  assign push_acc  = strobe && in_ready;
  assign lost      = strobe && !in_ready;
  assign pop       = out_valid && out_ready;

  pe_sync_fifo #(
    .WIDTH (IDX_W + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_acc),
    .pop_i   (pop),
    .wdata_i (in_entry),
    .rdata_o (out_data),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  always_comb begin
    err_cnt_d = err_cnt_q;
    drop_d    = drop_q | lost;
    if (push_acc && in_perr && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + CNT_W'(1);
    if (clr) begin
      err_cnt_d = '0;
      drop_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      drop_q    <= drop_d;
    end
  end

  assign err_cnt = err_cnt_q;
  assign drop    = drop_q;

endmodule
